hub75_scanner: RTL and testbench
================================

HUB75_SCANNER -- requirements
Module: hub75_scanner

Interface
REQ-001 SHALL have parameter BASE_TIME, default 8: DISPLAY length in clk cycles of bit plane 0.
REQ-002 SHALL have parameter PLANES, default 5: bit planes per colour channel, MSB-aligned; range 1..5.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port read_addr  output  10  framebuffer read address {row[3:0], col[5:0]}.
REQ-006 SHALL have port read_en  output  1  framebuffer read enable.
REQ-007 SHALL have port read_data_top  input  16  RGB565 pixel of row r, valid 1 clk after address+enable.
REQ-008 SHALL have port read_data_bottom  input  16  RGB565 pixel of row r+16, same timing.
REQ-009 SHALL have ports hub75_red, hub75_green, hub75_blue  output  2 each  bit 0 = top half (R1/G1/B1), bit 1 = bottom half (R2/G2/B2).
REQ-010 SHALL have port hub75_addr  output  4  panel row select A-D.
REQ-011 SHALL have ports hub75_clk, hub75_latch  output  1 each  panel shift clock and latch strobe.
REQ-012 SHALL have port hub75_oe  output  1  panel output enable, active low.
REQ-013 SHALL have port frame_done  output  1  one-clk pulse when a full frame has been scanned; drives the framebuffer buffer_toggle logic.

Function
REQ-014 SHALL sequence states IDLE -> PREFETCH -> SHIFT -> LATCH -> DISPLAY -> PREFETCH; IDLE lasts exactly 1 clk after reset.
REQ-015 SHALL, in PREFETCH (1 clk), drive read_en=1, read_addr={row, 6'd0}.
REQ-016 SHALL, in SHIFT, spend 2 clks per column c=0..63 (128 clks): phase 0 hub75_clk=0 and RGB outputs updated from read data for column c; phase 1 hub75_clk=1 and read_addr advanced to column c+1 (not advanced after c=63).
REQ-017 SHALL, for plane p, select bits red=data[11+(5-PLANES)+p], green=data[6+(5-PLANES)+p], blue=data[(5-PLANES)+p] of each pixel.
REQ-018 SHALL hold read_en=0 outside PREFETCH and SHIFT.
REQ-019 SHALL keep hub75_oe=1 in IDLE, PREFETCH, SHIFT and LATCH.
REQ-020 SHALL, in LATCH (1 clk), assert hub75_latch=1, hub75_clk=0, and load hub75_addr with the current row.
REQ-021 SHALL, in DISPLAY, drive hub75_oe=0 for exactly BASE_TIME<<p clks (BCM weighting), hub75_clk=0, hub75_latch=0.
REQ-022 SHALL, at DISPLAY end, increment p; at p=PLANES-1 wrap p to 0 and increment row; at row 15 wrap row to 0.
REQ-023 SHALL pulse frame_done for exactly the clk after DISPLAY of row 15, plane PLANES-1 ends (coincident with the next PREFETCH).
REQ-024 SHALL run continuously; no handshake stalls the scan.
REQ-025 SHALL hold hub75_addr stable from LATCH until the next LATCH.

Reset
REQ-026 SHALL, on reset=1 at a clk edge, force next-cycle outputs: read_addr=0, read_en=0, RGB=0, hub75_addr=0, hub75_clk=0, hub75_latch=0, hub75_oe=1, frame_done=0.
REQ-027 SHALL, on reset mid-operation (any state), abandon the current row/plane and restart at IDLE, row 0, plane 0; no frame_done emitted.
REQ-028 SHALL hold reset-state outputs for every cycle reset stays high.

Configuration
REQ-029 SHALL, with macro HUB75_BRIGHTNESS_EN defined, add input brightness[3:0] and, in DISPLAY, drive hub75_oe=0 only for the first ((brightness+1)*(BASE_TIME<<p))>>4 clks, hub75_oe=1 for the remainder; DISPLAY length unchanged.
REQ-030 SHALL, without HUB75_BRIGHTNESS_EN, omit the brightness port and drive hub75_oe=0 for the whole DISPLAY.
REQ-031 SHALL sample brightness only at DISPLAY entry.

Verification
REQ-032 Reset release, BASE_TIME=8, PLANES=5 -> IDLE 1 clk, read_en=1 with read_addr=0 on cycle 2, first hub75_clk rise on cycle 4.
REQ-033 Model RAM with top=16'hF800, bottom=16'h001F everywhere -> during every SHIFT hub75_red=2'b01, hub75_blue=2'b10, hub75_green=2'b00; exactly 64 hub75_clk rises per plane.
REQ-034 Count hub75_oe low per plane of row 0 -> 8,16,32,64,128 clks; hub75_latch one pulse before each, hub75_addr=0.
REQ-035 Run full frame -> frame_done one pulse after 16*5*(1+128+1)+16*248 = 14368 clks from first PREFETCH; hub75_addr sequence 0..15 then 0.
REQ-036 Assert reset for 1 clk mid-SHIFT of row 7 plane 3 -> next clk hub75_oe=1, read_en=0; scan restarts at row 0 plane 0, read_addr=0.
REQ-037 HUB75_BRIGHTNESS_EN, brightness=4'd7, plane 4 -> hub75_oe low 64 of 128 DISPLAY clks; brightness=4'd15 -> low all 128.

Source files
------------

// File: rtl/hub75_scanner.sv
// HUB75 panel scanner: reads a 64x32 RGB565 framebuffer and drives
// a 1/16-scan panel using binary-code-modulated bit planes.
// Ports:
//   clk, reset                        sole clock, sync active-high reset
//   read_addr, read_en                framebuffer read {row, col}
//   read_data_top, read_data_bottom   pixels of row r and r+16 (1 clk latency)
//   hub75_red/green/blue              bit0 = top half, bit1 = bottom half
//   hub75_addr, hub75_clk, hub75_latch, hub75_oe (active low)
//   frame_done                        1-clk pulse after each full frame
//   brightness (HUB75_BRIGHTNESS_EN)  OE duty in 1/16 steps, sampled at DISPLAY entry
module hub75_scanner #(
  parameter int BASE_TIME = 8,
  parameter int PLANES    = 5
) (
  input  logic        clk,
  input  logic        reset,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [3:0]  brightness,
`endif
  output logic [9:0]  read_addr,
  output logic        read_en,
  input  logic [15:0] read_data_top,
  input  logic [15:0] read_data_bottom,
  output logic [1:0]  hub75_red,
  output logic [1:0]  hub75_green,
  output logic [1:0]  hub75_blue,
  output logic [3:0]  hub75_addr,
  output logic        hub75_clk,
  output logic        hub75_latch,
  output logic        hub75_oe,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE, PREFETCH, SHIFT, LATCH, DISPLAY
  } state_t;

  state_t      state, state_n;
  logic [3:0]  row;
  logic [2:0]  plane;
  logic [5:0]  col;
  logic [15:0] cnt;
  logic [15:0] disp_len;
  logic [3:0]  off;
  logic        shift_last;
  logic        disp_last;
  logic        frame_last;
  logic [1:0]  red_q, green_q, blue_q;
  logic [3:0]  addr_q;
  logic        done_q;

  assign disp_len   = 16'(BASE_TIME) << plane;
  // planes are MSB-aligned within each 5-bit channel field
  assign off        = 4'(5 - PLANES) + {1'b0, plane};
  assign shift_last = (state == SHIFT) && (cnt == 16'd127);
  assign disp_last  = (state == DISPLAY) && (cnt == disp_len - 16'd1);
  assign frame_last = (row == 4'd15) && (plane == 3'(PLANES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = PREFETCH;
      PREFETCH: state_n = SHIFT;
      SHIFT:    if (shift_last) state_n = LATCH;
      LATCH:    state_n = DISPLAY;
      DISPLAY:  if (disp_last) state_n = PREFETCH;
      default:  state_n = IDLE;
    endcase
  end

`ifdef HUB75_BRIGHTNESS_EN
  logic [15:0] on_len;
  logic [19:0] on_prod;

  assign on_prod = (20'(brightness) + 20'd1) * 20'(disp_len);

  always_ff @(posedge clk) begin
    if (reset)               on_len <= '0;
    else if (state == LATCH) on_len <= 16'(on_prod >> 4);
  end

  assign hub75_oe = !((state == DISPLAY) && (cnt < on_len));
`else
  assign hub75_oe = (state != DISPLAY);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      row     <= '0;
      plane   <= '0;
      col     <= '0;
      cnt     <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        SHIFT: begin
          cnt <= cnt + 16'd1;
          // phase 0: capture column c; phase 1 then shows c+1 address
          if (!cnt[0]) begin
            red_q   <= {read_data_bottom[4'd11 + off],
                        read_data_top[4'd11 + off]};
            green_q <= {read_data_bottom[4'd6 + off],
                        read_data_top[4'd6 + off]};
            blue_q  <= {read_data_bottom[off],
                        read_data_top[off]};
            if (col != 6'd63) col <= col + 6'd1;
          end
          if (shift_last) begin
            cnt    <= '0;
            addr_q <= row;
          end
        end
        DISPLAY: begin
          cnt <= cnt + 16'd1;
          if (disp_last) begin
            cnt    <= '0;
            col    <= '0;
            done_q <= frame_last;
            if (plane == 3'(PLANES - 1)) begin
              plane <= '0;
              row   <= row + 4'd1;
            end else begin
              plane <= plane + 3'd1;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign read_en     = (state == PREFETCH) || (state == SHIFT);
  assign read_addr   = {row, col};
  assign hub75_clk   = (state == SHIFT) && cnt[0];
  assign hub75_latch = (state == LATCH);
  assign hub75_red   = red_q;
  assign hub75_green = green_q;
  assign hub75_blue  = blue_q;
  assign hub75_addr  = addr_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_hub75_scanner.sv
// Self-checking bench for hub75_scanner: directed pixel vectors,
// column addressing, BCM plane timing, full frame and mid-scan reset.
module tb_hub75_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  read_addr;
  logic        read_en;
  logic [15:0] rd_top, rd_bot;
  logic [1:0]  hub75_red, hub75_green, hub75_blue;
  logic [3:0]  hub75_addr;
  logic        hub75_clk, hub75_latch, hub75_oe, frame_done;
  logic [3:0]  bright;

  logic [15:0] c_top, c_bot;
  logic        pat;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  hub75_scanner dut (
    .clk              (clk),
    .reset            (reset),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness       (bright),
`endif
    .read_addr        (read_addr),
    .read_en          (read_en),
    .read_data_top    (rd_top),
    .read_data_bottom (rd_bot),
    .hub75_red        (hub75_red),
    .hub75_green      (hub75_green),
    .hub75_blue       (hub75_blue),
    .hub75_addr       (hub75_addr),
    .hub75_clk        (hub75_clk),
    .hub75_latch      (hub75_latch),
    .hub75_oe         (hub75_oe),
    .frame_done       (frame_done)
  );

  // Framebuffer model, one clock read latency.
  // Pattern mode: top red bit11 = col[0], bottom blue bit0 = col[1].
  always @(posedge clk) begin
    if (read_en) begin
      if (pat) begin
        rd_top <= {15'b0, read_addr[0]} << 11;
        rd_bot <= {15'b0, read_addr[1]};
      end else begin
        rd_top <= c_top;
        rd_bot <= c_bot;
      end
    end
  end

  typedef struct {
    logic [15:0] top;
    logic [15:0] bot;
    logic [1:0]  r;
    logic [1:0]  g;
    logic [1:0]  b;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, {7'b0, read_addr, read_en, hub75_red, hub75_green,
               hub75_blue, hub75_addr, hub75_clk, hub75_latch,
               hub75_oe, frame_done}, 32'h2);
  endtask

  // leaves the bench in the IDLE cycle right after reset release
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // wait for the next latch strobe; counts shift-clock rises
  task automatic wait_latch(output int rises, output bit rgb_ok,
                            output bit seen);
    int n;
    logic prev;
    rises  = 0;
    rgb_ok = 1'b1;
    seen   = 1'b0;
    prev   = hub75_clk;
    n      = 0;
    while (!seen && n < 2000) begin
      step();
      n++;
      if (hub75_clk && !prev) rises++;
      if (hub75_clk && !pat &&
          {hub75_red, hub75_green, hub75_blue} != 6'b01_00_10)
        rgb_ok = 1'b0;
      prev = hub75_clk;
      if (hub75_latch) seen = 1'b1;
    end
  endtask

  // count consecutive OE-low cycles starting the clk after latch
  task automatic count_oe(output int low);
    low = 0;
    step();
    while (!hub75_oe && low < 300) begin
      low++;
      step();
    end
  endtask

  task automatic run_planes();
    int rises, low, exp;
    bit ok, seen;
    for (int p = 0; p < 5; p++) begin
      wait_latch(rises, ok, seen);
      chk($sformatf("latch_seen_p%0d", p), 32'(seen), 32'd1);
      chk($sformatf("clk_rises_p%0d", p), rises, 64);
      chk($sformatf("rgb_shift_p%0d", p), 32'(ok), 32'd1);
      chk($sformatf("latch_addr_p%0d", p), 32'(hub75_addr), 32'd0);
      count_oe(low);
      exp = ((int'(bright) + 1) * (8 << p)) >> 4;
      chk($sformatf("oe_low_p%0d_b%0d", p, bright), low, exp);
    end
  endtask

  initial begin
    int n, lat, rises, low;
    bit ok, seen;

    vecs[0] = '{16'hF800, 16'h001F, 2'b01, 2'b00, 2'b10};
    vecs[1] = '{16'h0800, 16'h0040, 2'b01, 2'b10, 2'b00};
    vecs[2] = '{16'h0041, 16'h0801, 2'b10, 2'b01, 2'b11};
    vecs[3] = '{16'hF7BE, 16'hFFFF, 2'b10, 2'b10, 2'b10};
    vecs[4] = '{16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00};

    reset  = 1'b1;
    pat    = 1'b0;
    bright = 4'd15;
    c_top  = 16'hF800;
    c_bot  = 16'h001F;

    // reset held: outputs at reset values every cycle
    for (int i = 0; i < 4; i++) begin
      step();
      chk_reset_outs($sformatf("reset_hold_%0d", i));
    end
    reset = 1'b0;
    chk("idle_read_en", 32'(read_en), 32'd0);
    step();
    chk("prefetch_rd", {22'b0, read_en, read_addr}, {22'b0, 1'b1, 10'd0});
    step();
    chk("c3_hclk", 32'(hub75_clk), 32'd0);
    step();
    chk("c4_hclk", 32'(hub75_clk), 32'd1);

    // pixel bit selection, plane 0, column 0
    for (int v = 0; v < 5; v++) begin
      c_top = vecs[v].top;
      c_bot = vecs[v].bot;
      do_reset();
      step(); step(); step();
      chk($sformatf("vec%0d_rgb", v),
          {26'b0, hub75_red, hub75_green, hub75_blue},
          {26'b0, vecs[v].r, vecs[v].g, vecs[v].b});
    end

    // column addressing and data alignment
    pat = 1'b1;
    do_reset();
    step(); step(); step();
    for (int c = 0; c < 64; c++) begin
      chk($sformatf("col%0d_data", c),
          {30'b0, hub75_blue[1], hub75_red[0]}, 32'(c & 3));
      chk($sformatf("col%0d_addr", c), 32'(read_addr),
          32'((c == 63) ? 63 : c + 1));
      if (c < 63) begin
        step(); step();
      end
    end
    step();
    chk("latch_state", {28'b0, hub75_latch, hub75_clk, hub75_oe, read_en},
        32'b1010);
    pat = 1'b0;

    // BCM plane timing for row 0
    c_top = 16'hF800;
    c_bot = 16'h001F;
    do_reset();
    run_planes();
`ifdef HUB75_BRIGHTNESS_EN
    bright = 4'd7;
    do_reset();
    run_planes();
    bright = 4'd15;
`endif

    // full frame
    do_reset();
    step();
    n = 0;
    lat = 0;
    while (!frame_done && n < 20000) begin
      step();
      n++;
      if (hub75_latch) begin
        chk($sformatf("row_addr_%0d", lat), 32'(hub75_addr), 32'(lat / 5));
        lat++;
      end
    end
    chk("frame_len", n, 14368);
    chk("frame_latches", lat, 80);
    chk("frame_prefetch", {22'b0, read_en, read_addr}, {22'b0, 1'b1, 10'd0});
    step();
    chk("frame_pulse_1clk", 32'(frame_done), 32'd0);
    wait_latch(rises, ok, seen);
    chk("wrap_addr", {31'b0, seen, hub75_addr}, {31'b0, 1'b1, 4'd0});

    // reset mid-SHIFT of row 7 plane 3
    do_reset();
    n = 0;
    lat = 0;
    while (lat < 38 && n < 40000) begin
      step();
      n++;
      if (hub75_latch) lat++;
    end
    chk("mid_latches", lat, 38);
    count_oe(low);
    chk("r7p2_oe_low", low, 32);
    repeat (60) step();
    chk("mid_in_shift", {31'b0, read_en, hub75_oe}, 32'b11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_outs("mid_reset_outs");
    step();
    chk("restart_prefetch", {22'b0, read_en, read_addr},
        {22'b0, 1'b1, 10'd0});
    wait_latch(rises, ok, seen);
    chk("restart_latch", {31'b0, seen, hub75_addr}, {31'b0, 1'b1, 4'd0});
    count_oe(low);
    chk("restart_plane0", low, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
